// File: rtl/seq_detect_param_if.sv
// Bus bundle for seq_detect_param: configuration, serial input and detector outputs.
// The master drives configuration and data; the slave (detector) drives results.
interface seq_detect_param_if #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 16
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  logic               clear;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               din_valid;
  logic               din;
  logic               match;
  logic [CNT_W-1:0]   match_cnt;
  logic               armed;

  modport master (
    output clear, cfg_load, cfg_pattern, cfg_len, cfg_overlap, din_valid, din,
    input  match, match_cnt, armed
  );

  modport slave (
    input  clear, cfg_load, cfg_pattern, cfg_len, cfg_overlap, din_valid, din,
    output match, match_cnt, armed
  );
endinterface

// File: rtl/seq_detect_param.sv
// Run-time programmable serial pattern detector with a registered match pulse
// and a saturating match counter; overlap or non-overlap matching.
module seq_detect_param #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 16
) (
  input  logic                clk,
  input  logic                reset,
  seq_detect_param_if.slave   bus
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {DISABLED, FILL, RUN} state_t;

  state_t             state, state_next;
  logic [MAX_LEN-1:0] pat_r, pat_next;
  logic [MAX_LEN-1:0] hist, hist_next, hist_shift, mask;
  logic [LEN_W-1:0]   len_r, len_next, len_clamped;
  logic [LEN_W-1:0]   fill, fill_next, fill_inc;
  logic               ovl_r, ovl_next;
  logic               match_r, match_next, hit;
  logic [CNT_W-1:0]   cnt, cnt_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= DISABLED;
      pat_r   <= '0;
      len_r   <= '0;
      ovl_r   <= 1'b1;
      hist    <= '0;
      fill    <= '0;
      match_r <= 1'b0;
      cnt     <= '0;
    end else begin
      state   <= state_next;
      pat_r   <= pat_next;
      len_r   <= len_next;
      ovl_r   <= ovl_next;
      hist    <= hist_next;
      fill    <= fill_next;
      match_r <= match_next;
      cnt     <= cnt_next;
    end
  end

  always_comb begin
    state_next  = state;
    pat_next    = pat_r;
    len_next    = len_r;
    ovl_next    = ovl_r;
    hist_next   = hist;
    fill_next   = fill;
    match_next  = 1'b0;
    cnt_next    = cnt;
    mask        = '0;
    len_clamped = (bus.cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : bus.cfg_len;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < int'(len_r));
    end
    hist_shift = {hist[MAX_LEN-2:0], bus.din};
    fill_inc   = (fill < len_r) ? fill + LEN_W'(1) : fill;
    // A match needs len_r collected bits whose newest len_r history bits equal the pattern.
    hit = (len_r != '0) && (fill_inc >= len_r) && (((hist_shift ^ pat_r) & mask) == '0);

    if (bus.clear) begin
      hist_next  = '0;
      fill_next  = '0;
      cnt_next   = '0;
      state_next = (len_r == '0) ? DISABLED : FILL;
    end else if (bus.cfg_load) begin
      pat_next   = bus.cfg_pattern;
      len_next   = len_clamped;
      ovl_next   = bus.cfg_overlap;
      hist_next  = '0;
      fill_next  = '0;
      state_next = (len_clamped == '0) ? DISABLED : FILL;
    end else if (bus.din_valid) begin
      hist_next  = hist_shift;
      match_next = hit;
      fill_next  = (hit && !ovl_r) ? '0 : fill_inc;
      if (hit && (cnt != '1)) begin
        cnt_next = cnt + CNT_W'(1);
      end
      if (len_r == '0) begin
        state_next = DISABLED;
      end else if (fill_next == len_r) begin
        state_next = RUN;
      end else begin
        state_next = FILL;
      end
    end
  end

  assign bus.match     = match_r;
  assign bus.match_cnt = cnt;
  assign bus.armed     = (state == RUN);

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: a behavioural model predicts every cycle and a
// match scoreboard queue is compared one cycle after each driven beat.
module tb_seq_detect_param;
  logic clk;
  logic reset;

  seq_detect_param_if #(.MAX_LEN(8), .CNT_W(16)) bus_a ();
  seq_detect_param_if #(.MAX_LEN(8), .CNT_W(4))  bus_b ();

  seq_detect_param #(.MAX_LEN(8), .CNT_W(16)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  seq_detect_param #(.MAX_LEN(8), .CNT_W(4))  dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  logic [7:0] m_pat;
  int         m_len;
  bit         m_ovl;
  logic [7:0] m_hist;
  int         m_fill;
  int         m_cnt16;
  int         m_cnt4;
  bit         exp_q[$];

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    m_pat = '0; m_len = 0; m_ovl = 1'b1; m_hist = '0; m_fill = 0;
    m_cnt16 = 0; m_cnt4 = 0;
  endtask

  task automatic checkOutput(input string tag);
    bit exp_m;
    bit exp_armed;
    exp_armed = (m_len != 0) && (m_fill == m_len);
    if (exp_q.size() == 0) begin
      checkValue({tag, "_queue_empty"}, 32'd1, 32'd0);
    end else begin
      exp_m = exp_q.pop_front();
      checkValue({tag, "_match_a"}, 32'(bus_a.match), 32'(exp_m));
      checkValue({tag, "_match_b"}, 32'(bus_b.match), 32'(exp_m));
    end
    checkValue({tag, "_cnt_a"},   32'(bus_a.match_cnt), 32'(m_cnt16));
    checkValue({tag, "_cnt_b"},   32'(bus_b.match_cnt), 32'(m_cnt4));
    checkValue({tag, "_armed_a"}, 32'(bus_a.armed), 32'(exp_armed));
    checkValue({tag, "_armed_b"}, 32'(bus_b.armed), 32'(exp_armed));
  endtask

  task automatic applyStimulus(input string tag, input bit clr, input bit load,
                               input logic [7:0] pat, input logic [3:0] len, input bit ovl,
                               input bit valid, input bit d);
    bit exp_m;
    bit win;
    bus_a.clear = clr; bus_a.cfg_load = load; bus_a.cfg_pattern = pat; bus_a.cfg_len = len;
    bus_a.cfg_overlap = ovl; bus_a.din_valid = valid; bus_a.din = d;
    bus_b.clear = clr; bus_b.cfg_load = load; bus_b.cfg_pattern = pat; bus_b.cfg_len = len;
    bus_b.cfg_overlap = ovl; bus_b.din_valid = valid; bus_b.din = d;
    exp_m = 1'b0;
    if (clr) begin
      m_hist = '0; m_fill = 0; m_cnt16 = 0; m_cnt4 = 0;
    end else if (load) begin
      m_pat = pat; m_len = (len > 4'd8) ? 8 : int'(len); m_ovl = ovl;
      m_hist = '0; m_fill = 0;
    end else if (valid) begin
      m_hist = {m_hist[6:0], d};
      if (m_fill < m_len) m_fill++;
      win = 1'b1;
      for (int i = 0; i < m_len; i++) begin
        if (m_hist[i] != m_pat[i]) win = 1'b0;
      end
      if (m_len > 0 && m_fill >= m_len && win) begin
        exp_m = 1'b1;
        if (!m_ovl) m_fill = 0;
        if (m_cnt16 < 65535) m_cnt16++;
        if (m_cnt4 < 15) m_cnt4++;
      end
    end
    exp_q.push_back(exp_m);
    @(posedge clk);
    #1;
    bus_a.clear = 1'b0; bus_a.cfg_load = 1'b0; bus_a.din_valid = 1'b0;
    bus_b.clear = 1'b0; bus_b.cfg_load = 1'b0; bus_b.din_valid = 1'b0;
    checkOutput(tag);
  endtask

  task automatic feed(input string tag, input bit d);
    applyStimulus(tag, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, d);
  endtask

  task automatic idle(input string tag);
    applyStimulus(tag, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic loadCfg(input string tag, input logic [7:0] pat, input logic [3:0] len, input bit ovl);
    applyStimulus(tag, 1'b0, 1'b1, pat, len, ovl, 1'b0, 1'b0);
  endtask

  task automatic clearAll(input string tag);
    applyStimulus(tag, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [7:0] seq3;
    logic [7:0] a5;
    reset = 1'b1;
    bus_a.clear = 0; bus_a.cfg_load = 0; bus_a.cfg_pattern = 0; bus_a.cfg_len = 0;
    bus_a.cfg_overlap = 0; bus_a.din_valid = 0; bus_a.din = 0;
    bus_b.clear = 0; bus_b.cfg_load = 0; bus_b.cfg_pattern = 0; bus_b.cfg_len = 0;
    bus_b.cfg_overlap = 0; bus_b.din_valid = 0; bus_b.din = 0;
    modelReset();
    #12;
    checkValue("reset_match",  32'(bus_a.match), 32'd0);
    checkValue("reset_cnt",    32'(bus_a.match_cnt), 32'd0);
    checkValue("reset_armed",  32'(bus_a.armed), 32'd0);
    reset = 1'b0;

    $display("[TB] overlap run of ones");
    clearAll("t1_clr");
    loadCfg("t1_load", 8'h0F, 4'd4, 1'b1);
    for (int i = 0; i < 6; i++) feed("t1_beat", 1'b1);
    checkValue("t1_total", 32'(bus_a.match_cnt), 32'd3);

    $display("[TB] non-overlap run of ones");
    clearAll("t2_clr");
    loadCfg("t2_load", 8'h0F, 4'd4, 1'b0);
    for (int i = 0; i < 8; i++) feed("t2_beat", 1'b1);
    checkValue("t2_total", 32'(bus_a.match_cnt), 32'd2);

    $display("[TB] 8-bit pattern with valid gap");
    clearAll("t3_clr");
    loadCfg("t3_load", 8'b1011_0010, 4'd8, 1'b1);
    feed("t3_b", 1'b0); feed("t3_b", 1'b1); feed("t3_b", 1'b0); feed("t3_b", 1'b1);
    for (int i = 0; i < 3; i++) idle("t3_gap");
    feed("t3_b", 1'b1); feed("t3_b", 1'b0); feed("t3_b", 1'b0); feed("t3_b", 1'b1);
    feed("t3_last", 1'b0);
    checkValue("t3_total", 32'(bus_a.match_cnt), 32'd1);

    $display("[TB] length clamp and zero length");
    clearAll("t4_clr");
    loadCfg("t4_load12", 8'hA5, 4'd12, 1'b1);
    a5 = 8'hA5;
    for (int i = 7; i >= 0; i--) feed("t4_clamp", a5[i]);
    checkValue("t4_clamp_total", 32'(bus_a.match_cnt), 32'd1);
    loadCfg("t4_load0", 8'hFF, 4'd0, 1'b1);
    for (int i = 0; i < 20; i++) feed("t4_len0", 1'($urandom_range(0, 1)));
    checkValue("t4_len0_total", 32'(bus_a.match_cnt), 32'd1);

    $display("[TB] clear on completing beat");
    clearAll("t5_clr");
    loadCfg("t5_load", 8'h05, 4'd3, 1'b1);
    feed("t5_b", 1'b1); feed("t5_b", 1'b0);
    applyStimulus("t5_clr_hit", 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1);
    checkValue("t5_cnt_after_clear", 32'(bus_a.match_cnt), 32'd0);
    seq3 = 8'b0000_0101;
    for (int i = 2; i >= 0; i--) feed("t5_again", seq3[i]);
    checkValue("t5_total", 32'(bus_a.match_cnt), 32'd1);

    $display("[TB] length one and counter saturation");
    clearAll("t6_clr");
    loadCfg("t6_load", 8'h01, 4'd1, 1'b0);
    feed("t6_zero", 1'b0);
    for (int i = 0; i < 20; i++) feed("t6_one", 1'b1);
    checkValue("t6_sat_b", 32'(bus_b.match_cnt), 32'd15);
    checkValue("t6_cnt_a", 32'(bus_a.match_cnt), 32'd20);
    #2;
    reset = 1'b1;
    #1;
    checkValue("t6_async_match", 32'(bus_a.match), 32'd0);
    checkValue("t6_async_cnt_a", 32'(bus_a.match_cnt), 32'd0);
    checkValue("t6_async_cnt_b", 32'(bus_b.match_cnt), 32'd0);
    checkValue("t6_async_armed", 32'(bus_b.armed), 32'd0);
    modelReset();
    #3;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) feed("t6_disabled", 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
- Parametrised serial bit-pattern detector; successor to the team's fixed-pattern Mealy detector.
- Pattern, length and overlap mode are programmable at run time. Input is qualified by a valid strobe.
- Produces a registered one-cycle match pulse plus a saturating match counter.
- Sits on serial framing/sync paths, e.g. preamble, sync-word and run-length detection.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (2..32).
- CNT_W, 16, width of the match counter.

Ports:
- clk  input  1  clock.
- reset  input  1  reset, asynchronous, active-high.
- clear  input  1  synchronous clear of history, fill count, match_cnt and match.
- cfg_load  input  1  one-cycle strobe; latches cfg_pattern, cfg_len and cfg_overlap.
- cfg_pattern  input  MAX_LEN  pattern; bit cfg_len-1 is the first-received bit, bit 0 the last.
- cfg_len  input  $clog2(MAX_LEN+1)  pattern length in bits.
- cfg_overlap  input  1  1 = overlapping matches allowed; 0 = non-overlapping.
- din_valid  input  1  din is sampled on this cycle.
- din  input  1  serial data bit.
- match  output  1  one-cycle pulse, the cycle after the completing beat.
- match_cnt  output  CNT_W  saturating count of matches.
- armed  output  1  detector is in RUN state (enough bits collected to match).

Behaviour:
- Reset (async): all outputs 0; pattern = 0; len = 0; overlap = 1; history = 0; fill = 0; state DISABLED.
- Registered config: pat_r, len_r and ovl_r load on cfg_load.
  - cfg_len > MAX_LEN is clamped to MAX_LEN.
  - cfg_load also clears history and fill, and forces match = 0 on the next cycle.
- History shift register of MAX_LEN bits. On din_valid: hist <= {hist[MAX_LEN-2:0], din}, so the newest bit is at hist[0].
- fill counts valid beats since the last flush and saturates at len_r.
- State machine:
  - DISABLED: len_r == 0; no matches are produced.
  - FILL: fill < len_r.
  - RUN: fill == len_r.
  - Transitions: DISABLED->FILL on cfg_load with nonzero length. FILL->RUN when fill reaches len_r. RUN->FILL on a non-overlap match, clear or cfg_load. Any state->DISABLED on cfg_load with length 0.
- Match condition, evaluated on the din_valid beat:
  - Requirements: fill_next >= len_r, and hist_next[len_r-1:0] == pat_r[len_r-1:0], where fill_next and hist_next include the current bit.
  - match is registered and high exactly one cycle after the completing beat.
  - match is low on any cycle without a completing beat, including idle cycles with din_valid = 0.
- Overlap mode (ovl_r = 1): fill and history are kept after a match, so consecutive beats can each match.
- Non-overlap mode (ovl_r = 0): a match resets fill to 0; history shifts normally. The next match needs len_r fresh bits.
- match_cnt increments by 1 per match and saturates at 2^CNT_W-1 with no wrap.
- din_valid = 0: history, fill and state hold. Gaps between valid beats do not break a pattern.
- Simultaneous events, priority clear > cfg_load > din_valid:
  - With clear or cfg_load active, the current din beat is discarded and match is 0 next cycle.
  - clear does not alter the configuration.
- Reset mid-stream: everything returns to reset values immediately, and the configuration is lost.
- Length 1: a match occurs on every beat equal to pat_r[0], in either mode.

Test Plan:
- Load pattern 4'b1111, len 4, overlap=1; feed six valid 1s -> match pulses after beats 4, 5 and 6; match_cnt = 3; armed rises after beat 4.
- Same pattern with overlap=0; feed eight 1s -> matches after beats 4 and 8 only; match_cnt = 2.
- Load pattern 8'b1011_0010 (MAX_LEN=8, len 8); feed 0,1,0,1,1,0,0,1,0 with din_valid deasserted for 3 cycles mid-stream -> a single match one cycle after the final 0; no match elsewhere.
- Load cfg_len=12 with MAX_LEN=8 -> length clamped to 8. Load cfg_len=0 -> armed=0 and no match for 20 random bits.
- Overlap mode, pattern 3'b101; clear asserted on the same cycle as the completing beat -> no match, match_cnt = 0, fill = 0. Then 1,0,1 -> one match.
- CNT_W=4, pattern len 1 = 1'b1; feed 20 ones -> match_cnt saturates at 15. Assert async reset mid-stream -> match and match_cnt drop to 0 immediately and state is DISABLED.
